// File: rtl/wrr_pkt_scheduler.sv
// wrr_pkt_scheduler: packet-granular weighted round-robin merge of four AXI-Stream queues
module wrr_pkt_scheduler #(
   parameter int C_DATA_WIDTH  = 256,
   parameter int C_TUSER_WIDTH = 128,
   parameter int WEIGHT_WIDTH  = 8
) (
   input  logic                      axi_aclk,
   input  logic                      axi_resetn,
   input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata_0,
   input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb_0,
   input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser_0,
   input  logic                      s_axis_tvalid_0,
   input  logic                      s_axis_tlast_0,
   output logic                      s_axis_tready_0,
   input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata_1,
   input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb_1,
   input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser_1,
   input  logic                      s_axis_tvalid_1,
   input  logic                      s_axis_tlast_1,
   output logic                      s_axis_tready_1,
   input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata_2,
   input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb_2,
   input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser_2,
   input  logic                      s_axis_tvalid_2,
   input  logic                      s_axis_tlast_2,
   output logic                      s_axis_tready_2,
   input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata_3,
   input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb_3,
   input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser_3,
   input  logic                      s_axis_tvalid_3,
   input  logic                      s_axis_tlast_3,
   output logic                      s_axis_tready_3,
   output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   input  logic [WEIGHT_WIDTH-1:0]   weight_0,
   input  logic [WEIGHT_WIDTH-1:0]   weight_1,
   input  logic [WEIGHT_WIDTH-1:0]   weight_2,
   input  logic [WEIGHT_WIDTH-1:0]   weight_3,
   input  logic                      sched_en,
   output logic [1:0]                cur_queue,
   output logic                      busy,
   output logic                      pkt_done
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state;
   logic [1:0] ptr, sel, idx;
   logic [WEIGHT_WIDTH-1:0] credit, credit_dec;
   logic [WEIGHT_WIDTH-1:0] w [4];
   logic [C_DATA_WIDTH-1:0] td [4];
   logic [C_DATA_WIDTH/8-1:0] ts [4];
   logic [C_TUSER_WIDTH-1:0] tu [4];
   logic [3:0] tv, tl;
   logic found, send;

   assign w  = '{weight_0, weight_1, weight_2, weight_3};
   assign td = '{s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3};
   assign ts = '{s_axis_tstrb_0, s_axis_tstrb_1, s_axis_tstrb_2, s_axis_tstrb_3};
   assign tu = '{s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3};
   assign tv = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
   assign tl = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

   // Scan from the farthest offset down so the queue nearest ptr wins
   always_comb begin
      found = 1'b0;
      sel = ptr;
      idx = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (tv[idx] && w[idx] != '0) begin
            found = 1'b1;
            sel = idx;
         end
      end
   end

   // Reset gates the datapath immediately, not just from the next edge
   assign send = axi_resetn && state == SEND;
   assign m_axis_tvalid = send && tv[cur_queue];
   assign m_axis_tdata = td[cur_queue];
   assign m_axis_tstrb = ts[cur_queue];
   assign m_axis_tuser = tu[cur_queue];
   assign m_axis_tlast = tl[cur_queue];
   assign s_axis_tready_0 = send && cur_queue == 2'd0 && m_axis_tready;
   assign s_axis_tready_1 = send && cur_queue == 2'd1 && m_axis_tready;
   assign s_axis_tready_2 = send && cur_queue == 2'd2 && m_axis_tready;
   assign s_axis_tready_3 = send && cur_queue == 2'd3 && m_axis_tready;
   assign credit_dec = credit == '0 ? '0 : credit - WEIGHT_WIDTH'(1);

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         state <= IDLE;
         ptr <= '0;
         credit <= '0;
         cur_queue <= '0;
         busy <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         if (state == IDLE) begin
            if (sched_en && found) begin
               state <= SEND;
               busy <= 1'b1;
               cur_queue <= sel;
               if (!(sel == cur_queue && credit != '0)) credit <= w[sel];
            end
         end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state <= IDLE;
            busy <= 1'b0;
            pkt_done <= 1'b1;
            credit <= credit_dec;
            ptr <= credit_dec == '0 ? cur_queue + 2'd1 : cur_queue;
         end
      end
   end
endmodule

// File: tb/tb_wrr_pkt_scheduler.sv
// tb_wrr_pkt_scheduler: directed checks of grant order, packet integrity, reset and enable behaviour
module tb_wrr_pkt_scheduler;
   localparam int DW = 16, UW = 8, WW = 8;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0, m_tready = 1'b1, sched_en = 1'b1;
   logic [DW-1:0] td [4];
   logic [UW-1:0] tu [4];
   logic [WW-1:0] w [4];
   logic [3:0] tv, tl, tr;
   logic [DW/8-1:0] strb = '1;
   logic [DW-1:0] m_tdata;
   logic [DW/8-1:0] m_tstrb;
   logic [UW-1:0] m_tuser;
   logic m_tvalid, m_tlast, busy, pkt_done;
   logic [1:0] cur_queue;
   int beat [4], len [4], left [4];
   int order [$];
   logic [DW-1:0] beats [$];
   int n_cmp = 0, n_err = 0, pd_cnt = 0;
   logic tr2_seen = 1'b0;
   int expb [9] = '{0, 0, 1, 3, 3, 3, 0, 0, 1};
   int expd [8] = '{0, 1, 1, 0, 0, 0, 1, 1};

   wrr_pkt_scheduler #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .WEIGHT_WIDTH(WW)) dut (
      .axi_aclk(clk), .axi_resetn(rst_n),
      .s_axis_tdata_0(td[0]), .s_axis_tstrb_0(strb), .s_axis_tuser_0(tu[0]),
      .s_axis_tvalid_0(tv[0]), .s_axis_tlast_0(tl[0]), .s_axis_tready_0(tr[0]),
      .s_axis_tdata_1(td[1]), .s_axis_tstrb_1(strb), .s_axis_tuser_1(tu[1]),
      .s_axis_tvalid_1(tv[1]), .s_axis_tlast_1(tl[1]), .s_axis_tready_1(tr[1]),
      .s_axis_tdata_2(td[2]), .s_axis_tstrb_2(strb), .s_axis_tuser_2(tu[2]),
      .s_axis_tvalid_2(tv[2]), .s_axis_tlast_2(tl[2]), .s_axis_tready_2(tr[2]),
      .s_axis_tdata_3(td[3]), .s_axis_tstrb_3(strb), .s_axis_tuser_3(tu[3]),
      .s_axis_tvalid_3(tv[3]), .s_axis_tlast_3(tl[3]), .s_axis_tready_3(tr[3]),
      .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .weight_0(w[0]), .weight_1(w[1]), .weight_2(w[2]), .weight_3(w[3]),
      .sched_en(sched_en), .cur_queue(cur_queue), .busy(busy), .pkt_done(pkt_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Source model: tdata = {queue, beat index}; left = packets remaining, -1 = endless
   task automatic drive();
      for (int q = 0; q < 4; q++) begin
         tv[q] = left[q] != 0;
         td[q] = {8'(q), 8'(beat[q])};
         tu[q] = 8'(q + 1);
         tl[q] = beat[q] == len[q] - 1;
      end
   endtask

   task automatic tick();
      logic [3:0] hs;
      logic mh, mlast;
      logic [DW-1:0] md;
      #1;
      hs = tv & tr;
      mh = m_tvalid & m_tready;
      mlast = m_tlast;
      md = m_tdata;
      if (tr[2]) tr2_seen = 1'b1;
      @(posedge clk);
      #1;
      if (mh) begin
         beats.push_back(md);
         if (mlast) order.push_back(int'(md[15:8]));
      end
      for (int q = 0; q < 4; q++)
         if (hs[q]) begin
            if (tl[q]) begin
               beat[q] = 0;
               if (left[q] > 0) left[q]--;
            end else beat[q]++;
         end
      if (pkt_done) pd_cnt++;
      drive();
      #1;
   endtask

   task automatic setup(input int l);
      for (int q = 0; q < 4; q++) begin
         len[q] = l;
         beat[q] = 0;
      end
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      order.delete();
      beats.delete();
      pd_cnt = 0;
      tr2_seen = 1'b0;
   endtask

   initial begin
      w = '{8'd1, 8'd1, 8'd1, 8'd1};
      left = '{-1, -1, -1, -1};
      setup(1);
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_cur", cur_queue, 0);
      chk("rst_done", pkt_done, 0);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_tready", tr, 0);

      // equal weights: strict rotation, one bubble per packet
      repeat (16) tick();
      chk("rr_count", order.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("rr_q%0d", i), order[i], i % 4);
      chk("rr_done", pd_cnt, 8);

      w = '{8'd2, 8'd1, 8'd0, 8'd3};
      setup(1);
      do_reset();
      repeat (18) tick();
      chk("wt_count", order.size(), 9);
      for (int i = 0; i < 9; i++) chk($sformatf("wt_q%0d", i), order[i], expb[i]);
      chk("wt_tready2", tr2_seen, 0);

      // 4-beat packet with downstream back-pressure
      w = '{8'd1, 8'd1, 8'd1, 8'd1};
      left = '{0, 1, 0, 0};
      setup(4);
      do_reset();
      tick();
      chk("bp_busy", busy, 1);
      for (int i = 0; i < 7; i++) begin
         m_tready = (i % 2) == 0;
         chk($sformatf("bp_hold%0d", i), cur_queue, 1);
         tick();
      end
      chk("bp_done", pkt_done, 1);
      chk("bp_beats", beats.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("bp_beat%0d", i), beats[i], {8'd1, 8'(i)});
      m_tready = 1'b1;
      tick();
      chk("bp_done_pulse", pkt_done, 0);
      chk("bp_done_cnt", pd_cnt, 1);
      chk("bp_idle", busy, 0);

      // queue 0 runs dry mid-turn, then returns with a fresh credit
      w = '{8'd3, 8'd2, 8'd1, 8'd1};
      left = '{1, -1, 0, 0};
      setup(1);
      do_reset();
      repeat (6) tick();
      chk("dry_count1", order.size(), 3);
      left[0] = -1;
      drive();
      repeat (10) tick();
      chk("dry_count2", order.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("dry_q%0d", i), order[i], expd[i]);

      // reset in the middle of a 3-beat packet from queue 1
      w = '{8'd1, 8'd1, 8'd1, 8'd1};
      left = '{0, -1, 0, 0};
      setup(3);
      do_reset();
      tick();
      tick();
      chk("mr_cur_pre", cur_queue, 1);
      chk("mr_valid_pre", m_tvalid, 1);
      chk("mr_tuser_pre", m_tuser, 2);
      rst_n = 1'b0;
      tick();
      chk("mr_busy", busy, 0);
      chk("mr_cur", cur_queue, 0);
      chk("mr_mvalid", m_tvalid, 0);
      chk("mr_tready", tr, 0);
      chk("mr_no_tlast", order.size(), 0);
      left[0] = -1;
      drive();
      rst_n = 1'b1;
      tick();
      chk("mr_regrant_busy", busy, 1);
      chk("mr_regrant_q", cur_queue, 0);

      // sched_en dropped mid-packet
      left = '{0, 0, 1, 0};
      setup(3);
      do_reset();
      tick();
      tick();
      sched_en = 1'b0;
      tick();
      tick();
      chk("en_done", pkt_done, 1);
      chk("en_count", order.size(), 1);
      chk("en_q", order[0], 2);
      left[2] = -1;
      drive();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("en_idle%0d", i), busy, 0);
      end
      chk("en_nogrant", order.size(), 1);
      sched_en = 1'b1;
      tick();
      chk("en_regrant_busy", busy, 1);
      chk("en_regrant_q", cur_queue, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/wrr_pkt_scheduler.md
WRR_PKT_SCHEDULER -- requirements
Module: wrr_pkt_scheduler

Interface
REQ-001 C_DATA_WIDTH, default 256: tdata width of all streams.
REQ-002 C_TUSER_WIDTH, default 128: tuser width of all streams.
REQ-003 WEIGHT_WIDTH, default 8: width of each per-queue packet-credit weight.
REQ-004 axi_aclk  in  1  single clock; all logic on its rising edge.
REQ-005 axi_resetn  in  1  reset, synchronous, active-low.
REQ-006 s_axis_tdata_N/tstrb_N/tuser_N/tvalid_N/tlast_N  in  C_DATA_WIDTH/C_DATA_WIDTH/8/C_TUSER_WIDTH/1/1  slave stream N (N=0..3), one per packet-generator queue.
REQ-007 s_axis_tready_N  out  1  ready for slave stream N.
REQ-008 m_axis_tdata/tstrb/tuser/tvalid/tlast  out  as slave  merged master stream toward pkt counting/MAC.
REQ-009 m_axis_tready  in  1  downstream ready.
REQ-010 weight_N  in  WEIGHT_WIDTH  packets queue N may send per turn; 0 = queue disabled.
REQ-011 sched_en  in  1  1 = new grants allowed.
REQ-012 cur_queue  out  2  index of granted queue.
REQ-013 busy  out  1  1 while in SEND.
REQ-014 pkt_done  out  1  one-cycle pulse on master tlast handshake.

Function
REQ-015 FSM states IDLE, SEND; packet-granular: grant never changes between first beat and tlast beat.
REQ-016 IDLE: if sched_en=1, scan queues ptr, ptr+1, ... (mod 4); first N with tvalid_N=1 and weight_N!=0 is granted; cur_queue<=N, state<=SEND next edge.
REQ-017 Credit on grant: if N==last granted queue and credit!=0, credit kept; else credit<=weight_N.
REQ-018 IDLE: all s_axis_tready_N=0, m_axis_tvalid=0; grant costs exactly one bubble cycle.
REQ-019 SEND: m_axis_* = s_axis_*_cur_queue combinationally (zero latency); s_axis_tready_cur=m_axis_tready; other tready=0.
REQ-020 Beat transfers only when m_axis_tvalid & m_axis_tready; tvalid low or tready low stalls with no state change.
REQ-021 On tlast handshake: pkt_done=1 next cycle, credit<=credit-1, state<=IDLE.
REQ-022 On that event: if credit-1==0, ptr<=cur_queue+1 mod 4 (wraps 3->0) and credit<=0; else ptr<=cur_queue.
REQ-023 credit is WEIGHT_WIDTH bits, never decremented below 0.
REQ-024 weight_N sampled only at grant; changes mid-turn take effect at next reload.
REQ-025 sched_en=0 during SEND: current packet completes; no new grant in IDLE.
REQ-026 No eligible queue in IDLE: remain IDLE, ptr unchanged.
REQ-027 Simultaneous requests: lowest index at or after ptr wins (round-robin, no starvation for weight>=1).

Reset
REQ-028 axi_resetn=0 at edge: state<=IDLE, ptr<=0, credit<=0, cur_queue<=0, busy<=0, pkt_done<=0; all tready=0, m_axis_tvalid=0 while asserted.
REQ-029 Reset mid-packet aborts packet immediately; no tlast generated; first grant after release follows REQ-016 from ptr=0.

Verification
REQ-030 All 4 queues backlogged, weights 1,1,1,1, tready=1 -> single-beat packets from queues 0,1,2,3,0,... each separated by one bubble cycle.
REQ-031 Weights 2,1,0,3, all backlogged -> packet order 0,0,1,3,3,3,0,0,...; queue 2 never granted, tready_2 always 0.
REQ-032 Queue 1 sends 4-beat packet, m_axis_tready toggled 1,0,1 -> all 4 beats delivered in order, no grant change, pkt_done once after beat 4.
REQ-033 Queue 0 weight 3 but empty after 1 packet, queue 1 valid -> queue 1 granted with credit=weight_1; queue 0 later reloaded to 3.
REQ-034 Reset asserted on beat 2 of 3-beat packet -> next cycle tready/tvalid=0, busy=0, cur_queue=0; after release queue 0 granted first if valid.
REQ-035 sched_en dropped mid-packet -> packet completes with tlast, then IDLE with no grant until sched_en=1.
